// File: rtl/stuff_nrzi_tx.sv
// Bit-stuffing NRZI line transmitter: stuffs a 0 after six consecutive 1s, buffers the
// stuffed stream in a small FIFO and drives D+/D- with NRZI coding followed by SE0,SE0,J EOP.
module stuff_nrzi_tx #(
    parameter int unsigned FIFO_DEPTH = 32
) (
    input  logic clk,
    input  logic rst_b,
    input  logic bit_in,
    input  logic bit_valid,
    input  logic pkt_end,
    output logic dp,
    output logic dm,
    output logic tx_oe,
    output logic busy,
    output logic eop_done,
    output logic overflow,
    output logic underrun
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned OW = 3;

    typedef enum logic [2:0] {
        IDLE,
        TX,
        SE0_1,
        SE0_2,
        EOP_J
    } state_e;

    state_e               state_q, state_d;
    logic [FIFO_DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [OW-1:0]        ones_q, ones_d;
    logic                 seen_q, seen_d;
    logic                 pending_q, pending_d;
    logic                 dp_q, dp_d;
    logic                 dm_q, dm_d;
    logic                 oe_q, oe_d;
    logic                 busy_q, busy_d;
    logic                 eop_q, eop_d;
    logic                 ovf_q, ovf_d;
    logic                 unr_q, unr_d;

    logic                 head;
    logic                 rd;
    logic                 stuff;
    logic [1:0]           n_wr;
    logic [1:0]           n_acc;
    logic [CW-1:0]        space;

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        state_d   = state_q;
        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ones_d    = ones_q;
        seen_d    = seen_q;
        pending_d = pending_q;
        dp_d      = dp_q;
        dm_d      = dm_q;
        oe_d      = oe_q;
        eop_d     = 1'b0;
        ovf_d     = ovf_q;
        unr_d     = unr_q;
        rd        = 1'b0;
        stuff     = 1'b0;
        n_wr      = 2'd0;
        n_acc     = 2'd0;
        space     = '0;

        // Stuffer: sixth consecutive 1 gets a 0 appended in the same edge
        if (bit_valid) begin
            seen_d = 1'b1;
            if (bit_in) begin
                if (ones_q == OW'(5)) begin
                    stuff  = 1'b1;
                    ones_d = '0;
                end else begin
                    ones_d = ones_q + OW'(1);
                end
            end else begin
                ones_d = '0;
            end
            n_wr = stuff ? 2'd2 : 2'd1;
        end

        case (state_q)
            IDLE: begin
                oe_d = 1'b0;
                dp_d = 1'b1;
                dm_d = 1'b0;
                if (count_q != '0) begin
                    // First bit is always referenced to J
                    rd      = 1'b1;
                    state_d = TX;
                    oe_d    = 1'b1;
                    dp_d    = head;
                    dm_d    = ~head;
                end
            end
            TX: begin
                oe_d = 1'b1;
                if (count_q != '0) begin
                    rd   = 1'b1;
                    dp_d = head ? dp_q : ~dp_q;
                    dm_d = head ? dm_q : ~dm_q;
                end else if (pending_q) begin
                    state_d   = SE0_1;
                    pending_d = 1'b0;
                    dp_d      = 1'b0;
                    dm_d      = 1'b0;
                end else begin
                    unr_d = 1'b1;
                end
            end
            SE0_1: begin
                state_d = SE0_2;
                oe_d    = 1'b1;
                dp_d    = 1'b0;
                dm_d    = 1'b0;
            end
            SE0_2: begin
                state_d = EOP_J;
                oe_d    = 1'b1;
                dp_d    = 1'b1;
                dm_d    = 1'b0;
            end
            EOP_J: begin
                state_d = IDLE;
                oe_d    = 1'b0;
                dp_d    = 1'b1;
                dm_d    = 1'b0;
                eop_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
                oe_d    = 1'b0;
                dp_d    = 1'b1;
                dm_d    = 1'b0;
            end
        endcase

        // Packet end closes the packet for the stuffer; ignored if nothing was accepted
        if (pkt_end && (seen_q || bit_valid)) begin
            pending_d = 1'b1;
            seen_d    = 1'b0;
            ones_d    = '0;
        end

        // FIFO update: the pop this edge frees a slot for this edge's writes
        space = CW'(FIFO_DEPTH) - count_q + CW'(rd);
        if (CW'(n_wr) > space) begin
            n_acc = space[1:0];
            ovf_d = 1'b1;
        end else begin
            n_acc = n_wr;
        end
        if (n_acc != 2'd0) begin
            mem_d[wr_ptr_q] = bit_in;
        end
        if (n_acc == 2'd2) begin
            mem_d[wr_ptr_q + AW'(1)] = 1'b0;
        end
        wr_ptr_d = wr_ptr_q + AW'(n_acc);
        rd_ptr_d = rd_ptr_q + AW'(rd);
        count_d  = count_q + CW'(n_acc) - CW'(rd);

        busy_d = (state_d != IDLE) || (count_d != '0);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ones_q    <= '0;
            seen_q    <= 1'b0;
            pending_q <= 1'b0;
            dp_q      <= 1'b1;
            dm_q      <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            eop_q     <= 1'b0;
            ovf_q     <= 1'b0;
            unr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ones_q    <= ones_d;
            seen_q    <= seen_d;
            pending_q <= pending_d;
            dp_q      <= dp_d;
            dm_q      <= dm_d;
            oe_q      <= oe_d;
            busy_q    <= busy_d;
            eop_q     <= eop_d;
            ovf_q     <= ovf_d;
            unr_q     <= unr_d;
        end
    end

    assign dp       = dp_q;
    assign dm       = dm_q;
    assign tx_oe    = oe_q;
    assign busy     = busy_q;
    assign eop_done = eop_q;
    assign overflow = ovf_q;
    assign underrun = unr_q;

endmodule

// File: doc/stuff_nrzi_tx.md
STUFF_NRZI_TX -- requirements
Module: stuff_nrzi_tx

Interface
REQ-001 Parameter FIFO_DEPTH, default 32, number of entries in the stuffed-bit buffer (power of two).
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst_b  input  1  reset: rst_b, asynchronous, active-low; clock clk.
REQ-004 bit_in  input  1  serial packet bit (SYNC, PID, payload, CRC) from the encoder, MSB-first order as produced.
REQ-005 bit_valid  input  1  bit_in is a packet bit this cycle.
REQ-006 pkt_end  input  1  one-cycle pulse marking that the packet's last bit has been presented (same cycle or earlier).
REQ-007 dp  output  1  D+ line level.
REQ-008 dm  output  1  D- line level.
REQ-009 tx_oe  output  1  line driver enable.
REQ-010 busy  output  1  FSM not in IDLE, or FIFO non-empty.
REQ-011 eop_done  output  1  one-cycle pulse when the EOP J cycle completes.
REQ-012 overflow  output  1  sticky: a write was dropped because the FIFO was full.
REQ-013 underrun  output  1  sticky: FIFO empty in TX with no pending pkt_end.

Function
REQ-014 Stuffer counts consecutive 1s on accepted bits; counter clears on any 0, after a stuff insertion, and at first bit_valid following IDLE/EOP.
REQ-015 When the accepted bit is the sixth consecutive 1, a 0 stuff bit is written immediately after it, in the same edge (2 writes that cycle).
REQ-016 Stuff insertion applies to the final packet bit too; a packet ending on six 1s is followed by a stuffed 0 before EOP.
REQ-017 FIFO: up to 2 writes and 1 read per edge; occupancy updates as count + writes - read; wrap-around by pointer modulo FIFO_DEPTH.
REQ-018 Write that would exceed FIFO_DEPTH: excess bit(s) dropped, overflow set to 1 until reset.
REQ-019 pkt_end latched into a pending flag; pkt_end with no bit ever accepted since last EOP is ignored.
REQ-020 FSM states IDLE, TX, SE0_1, SE0_2, EOP_J.
REQ-021 IDLE: if FIFO non-empty, pop head, go TX; NRZI level preset to J before applying popped bit.
REQ-022 TX: each edge pops one bit; bit 0 toggles line state, bit 1 holds it.
REQ-023 TX with FIFO empty and pending set: go SE0_1, clear pending.
REQ-024 TX with FIFO empty and pending clear: hold current line state, set underrun, stay TX.
REQ-025 SE0_1 -> SE0_2 -> EOP_J -> IDLE, one cycle each, unconditional; eop_done = 1 during the cycle after EOP_J exits (registered pulse, one cycle).
REQ-026 Line encoding: J = dp 1/dm 0; K = dp 0/dm 1; SE0 = dp 0/dm 0; dp/dm/tx_oe are registered.
REQ-027 tx_oe = 1 in TX, SE0_1, SE0_2, EOP_J; 0 in IDLE; idle line is J.
REQ-028 Bits accepted during SE0_1/SE0_2/EOP_J are buffered; the next packet starts from IDLE after EOP_J with ones counter and NRZI level reset.
REQ-029 Latency: bit sampled at edge t (FIFO empty, FSM IDLE) drives dp/dm after edge t+1.
REQ-030 bit_valid and pkt_end in same cycle: bit accepted as the last bit, then pending set.

Reset
REQ-031 On rst_b low: FSM IDLE, FIFO empty, pointers 0, ones counter 0, pending 0, dp 1, dm 0, tx_oe 0, busy 0, eop_done 0, overflow 0, underrun 0.
REQ-032 Reset mid-packet aborts transmission immediately; buffered bits discarded; line returns to idle J.

Verification
REQ-033 Reset -> dp=1, dm=0, tx_oe=0, busy=0, overflow=0, underrun=0.
REQ-034 Bits 00000001 then pkt_end -> dp sequence 0,1,0,1,0,1,0,0, then SE0 x2, J x1, eop_done pulse, tx_oe falls.
REQ-035 Bits 1111111 -> 8 line bits 11111101; dp = 1,1,1,1,1,1,0,0.
REQ-036 Bits 111111 with pkt_end on last bit -> 7 line bits 1111110 then SE0 x2, J.
REQ-037 Second packet bits presented during SE0_1 -> buffered, transmitted starting the cycle after EOP_J, first bit referenced to J, no stuff carry-over.
REQ-038 220 consecutive 1s without pause -> overflow=1 stays set until rst_b; reset mid-stream -> dp=1, dm=0, tx_oe=0 immediately.
